// File: rtl/pec_pkg.sv
// Shared constants and helpers for the pulse event capture block.
package pec_pkg;

    localparam int TS_W_DEF   = 16;
    localparam int DEPTH_DEF  = 4;
    localparam int DROP_W_DEF = 8;

    // Occupancy needs one extra bit so that "full" (== DEPTH) is representable.
    function automatic int lvl_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pec_fifo.sv
// First-word-fall-through event store; rdata always shows the oldest entry.
// A push is taken when not full, or when full with a pop in the same cycle.
module pec_fifo
    import pec_pkg::*;
#(
    parameter int W     = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       clk2,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [lvl_w(DEPTH)-1:0]    level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = lvl_w(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign rdata = mem[rd_ptr];
    assign level = count;

    // Pointers are exactly PW bits wide, so DEPTH being a power of two gives modulo wrap.
    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pulse_evt_capture.sv
// Timestamps rising edges of sync_in into a small FIFO and accounts for drops.
// Optional glitch filter on the input: define PEC_GLITCH_FILTER_EN.
module pulse_evt_capture
    import pec_pkg::*;
#(
    parameter int TS_W   = TS_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int DROP_W = DROP_W_DEF
) (
    input  logic                     clk2,
    input  logic                     rst_n,
    input  logic                     sync_in,
    input  logic                     evt_ready,
    input  logic                     ovf_clr,
    output logic                     evt_valid,
    output logic [TS_W-1:0]          evt_ts,
    output logic                     ovf,
    output logic [DROP_W-1:0]        drop_cnt,
    output logic [lvl_w(DEPTH)-1:0]  level
);

    logic [TS_W-1:0] ts_cnt;
    logic            prev;
    logic            det_lvl;
    logic            rise;
    logic            pop;
    logic            full;
    logic            empty;
    logic            drop;

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            ts_cnt <= '0;
        end else begin
            ts_cnt <= ts_cnt + 1'b1;
        end
    end

`ifdef PEC_GLITCH_FILTER_EN
    // The filtered level only follows sync_in once two consecutive samples agree.
    logic samp_q;

    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            samp_q <= 1'b1;
        end else begin
            samp_q <= sync_in;
        end
    end

    assign det_lvl = (sync_in == samp_q) ? sync_in : prev;
`else
    assign det_lvl = sync_in;
`endif

    // prev resets high so a level already high at reset release is not an event.
    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b1;
        end else begin
            prev <= det_lvl;
        end
    end

    assign rise = det_lvl && !prev;

    // Handshake: the head entry transfers on a cycle where evt_valid and evt_ready are
    // both high; evt_ts holds while evt_valid is high and evt_ready is low, and
    // evt_ready has no effect while evt_valid is low.
    assign evt_valid = !empty;
    assign pop       = evt_valid && evt_ready;
    assign drop      = rise && full && !pop;

    pec_fifo #(
        .W     (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk2  (clk2),
        .rst_n (rst_n),
        .push  (rise),
        .wdata (ts_cnt),
        .pop   (pop),
        .rdata (evt_ts),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    // A drop coinciding with a clear counts as the first drop after the clear.
    always_ff @(posedge clk2 or negedge rst_n) begin
        if (!rst_n) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            ovf <= 1'b1;
            if (ovf_clr) begin
                drop_cnt <= DROP_W'(1);
            end else if (!(&drop_cnt)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end else if (ovf_clr) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_pulse_evt_capture.sv
// Self-checking bench for pulse_evt_capture: directed scenarios plus a long random run
// against a queue-based reference model.
module tb_pulse_evt_capture;

  localparam int TS_W   = 16;
  localparam int DEPTH  = 4;
  localparam int DROP_W = 8;
  localparam int LW     = $clog2(DEPTH) + 1;
  localparam int DROP_MAX = (1 << DROP_W) - 1;
`ifdef PEC_GLITCH_FILTER_EN
  localparam int FLT = 1;
`else
  localparam int FLT = 0;
`endif

  logic              clk2 = 1'b0;
  logic              rst_n;
  logic              sync_in;
  logic              evt_ready;
  logic              ovf_clr;
  logic              evt_valid;
  logic [TS_W-1:0]   evt_ts;
  logic              ovf;
  logic [DROP_W-1:0] drop_cnt;
  logic [LW-1:0]     level;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [TS_W-1:0] exp_q[$];
  int   m_cnt;
  logic m_prev;
  logic m_last;
  logic m_ovf;
  int   m_drop;

  // clock / reset
  always #5 clk2 = ~clk2;

  pulse_evt_capture #(
    .TS_W   (TS_W),
    .DEPTH  (DEPTH),
    .DROP_W (DROP_W)
  ) dut (
    .clk2      (clk2),
    .rst_n     (rst_n),
    .sync_in   (sync_in),
    .evt_ready (evt_ready),
    .ovf_clr   (ovf_clr),
    .evt_valid (evt_valid),
    .evt_ts    (evt_ts),
    .ovf       (ovf),
    .drop_cnt  (drop_cnt),
    .level     (level)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_cnt  = 0;
    m_prev = 1'b1;
    m_last = 1'b1;
    m_ovf  = 1'b0;
    m_drop = 0;
  endtask

  // One clock of the spec rules, driven only by the bench's own inputs.
  task automatic model_step();
    logic lvl;
    logic rise;
    logic pop;
    logic drop;
    if (FLT != 0) lvl = (sync_in == m_last) ? sync_in : m_prev;
    else          lvl = sync_in;
    m_last = sync_in;
    rise   = lvl && !m_prev;
    m_prev = lvl;
    pop    = (exp_q.size() != 0) && evt_ready;
    drop   = rise && (exp_q.size() == DEPTH) && !pop;
    if (pop) void'(exp_q.pop_front());
    if (rise && !drop) exp_q.push_back(TS_W'(m_cnt));
    if (drop) begin
      m_ovf  = 1'b1;
      m_drop = ovf_clr ? 1 : ((m_drop < DROP_MAX) ? m_drop + 1 : DROP_MAX);
    end else if (ovf_clr) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end
    m_cnt = (m_cnt + 1) % (1 << TS_W);
  endtask

  // scoreboard comparison of every output against the model
  task automatic check_outputs();
    check_eq("level", 32'(level), exp_q.size());
    check_eq("evt_valid", 32'(evt_valid), 32'(exp_q.size() != 0));
    check_eq("ovf", 32'(ovf), 32'(m_ovf));
    check_eq("drop_cnt", 32'(drop_cnt), m_drop);
    if (exp_q.size() != 0) check_eq("evt_ts", 32'(evt_ts), 32'(exp_q[0]));
  endtask

  // driver: inputs change at the falling edge, outputs are checked at the next falling edge
  task automatic step_cycle(input logic s, input logic r, input logic c);
    sync_in   = s;
    evt_ready = r;
    ovf_clr   = c;
    @(posedge clk2);
    model_step();
    @(negedge clk2);
    check_outputs();
  endtask

  task automatic run_to(input int target, input logic s, input logic r, input logic c);
    for (int k = 0; k < (1 << TS_W) && m_cnt != target; k++) step_cycle(s, r, c);
  endtask

  task automatic pulse(input logic r);
    step_cycle(1'b1, r, 1'b0);
    step_cycle(1'b1, r, 1'b0);
    step_cycle(1'b0, r, 1'b0);
    step_cycle(1'b0, r, 1'b0);
  endtask

  task automatic apply_reset();
    sync_in   = 1'b1;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_eq("rst_level", 32'(level), 0);
    check_eq("rst_valid", 32'(evt_valid), 0);
    check_eq("rst_ts", 32'(evt_ts), 0);
    check_eq("rst_ovf", 32'(ovf), 0);
    check_eq("rst_drop", 32'(drop_cnt), 0);
    repeat (2) @(posedge clk2);
    @(negedge clk2);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_500_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

  initial begin
    rst_n     = 1'b1;
    sync_in   = 1'b1;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;
    model_reset();
    @(negedge clk2);
    apply_reset();

    // level held high across reset release is not an event
    step_cycle(1'b1, 1'b1, 1'b0);
    step_cycle(1'b1, 1'b1, 1'b0);
    check_eq("hold_high_level", 32'(level), 0);
    check_eq("hold_high_valid", 32'(evt_valid), 0);

    // rise at counter 5
    run_to(5 - FLT, 1'b0, 1'b0, 1'b0);
    step_cycle(1'b1, 1'b0, 1'b0);
    step_cycle(1'b1, 1'b0, 1'b0);
    check_eq("first_valid", 32'(evt_valid), 1);
    check_eq("first_ts", 32'(evt_ts), 32'h5);
    step_cycle(1'b0, 1'b1, 1'b0);
    check_eq("first_drained", 32'(level), 0);
    step_cycle(1'b0, 1'b0, 1'b0);

`ifdef PEC_GLITCH_FILTER_EN
    begin : glitch_blk
      int t0;
      step_cycle(1'b1, 1'b0, 1'b0);
      step_cycle(1'b0, 1'b0, 1'b0);
      step_cycle(1'b0, 1'b0, 1'b0);
      check_eq("glitch_ignored", 32'(level), 0);
      t0 = m_cnt;
      pulse(1'b0);
      check_eq("flt_level", 32'(level), 1);
      check_eq("flt_ts", 32'(evt_ts), 32'(TS_W'(t0 + 1)));
      step_cycle(1'b0, 1'b1, 1'b0);
    end
`endif

    // six rises into a four-deep FIFO with no consumer
    for (int i = 0; i < 6; i++) pulse(1'b0);
    check_eq("full_level", 32'(level), 4);
    check_eq("full_ovf", 32'(ovf), 1);
    check_eq("full_drop", 32'(drop_cnt), 2);
    step_cycle(1'b0, 1'b0, 1'b1);
    check_eq("clr_ovf", 32'(ovf), 0);
    check_eq("clr_drop", 32'(drop_cnt), 0);

    // full FIFO, rise and pop in the same cycle
    step_cycle(1'b1, 1'(FLT == 0), 1'b0);
    step_cycle(1'b1, 1'(FLT == 1), 1'b0);
    check_eq("push_pop_level", 32'(level), 4);
    check_eq("push_pop_drop", 32'(drop_cnt), 0);
    check_eq("push_pop_ovf", 32'(ovf), 0);
    step_cycle(1'b0, 1'b0, 1'b0);
    step_cycle(1'b0, 1'b0, 1'b0);

    // a drop on the same cycle as a clear
    pulse(1'b0);
    step_cycle(1'b1, 1'b0, 1'(FLT == 0));
    step_cycle(1'b1, 1'b0, 1'(FLT == 1));
    check_eq("drop_vs_clr_ovf", 32'(ovf), 1);
    check_eq("drop_vs_clr_cnt", 32'(drop_cnt), 1);
    step_cycle(1'b0, 1'b0, 1'b0);
    step_cycle(1'b0, 1'b0, 1'b0);

    // drop counter saturation
    repeat (DROP_MAX + 5) pulse(1'b0);
    check_eq("sat_drop", 32'(drop_cnt), DROP_MAX);
    check_eq("sat_level", 32'(level), 4);
    repeat (6) step_cycle(1'b0, 1'b1, 1'b1);
    check_eq("drain_level", 32'(level), 0);
    check_eq("drain_ovf", 32'(ovf), 0);

    // random traffic, consumer rate changes every 1024 cycles
    begin : rnd_blk
      int pct;
      pct = 50;
      while (m_cnt < 32'hFFE0) begin
        if ((m_cnt % 1024) == 0) pct = int'($urandom_range(5, 100));
        step_cycle(1'($urandom_range(0, 1)), 1'(int'($urandom_range(0, 99)) < pct),
                   1'($urandom_range(0, 63) == 0));
      end
    end

    // timestamp wrap
    run_to(32'hFFF0, 1'b0, 1'b1, 1'b1);
    check_eq("pre_wrap_level", 32'(level), 0);
    run_to(32'hFFFF - FLT, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k <= FLT; k++) step_cycle(1'b1, 1'b0, 1'b0);
    step_cycle(1'b0, 1'b0, 1'b0);
    step_cycle(1'b0, 1'b0, 1'b0);
    for (int k = 0; k <= FLT; k++) step_cycle(1'b1, 1'b0, 1'b0);
    step_cycle(1'b0, 1'b0, 1'b0);
    step_cycle(1'b0, 1'b0, 1'b0);
    check_eq("wrap_level", 32'(level), 2);
    check_eq("wrap_ts_ffff", 32'(evt_ts), 32'hFFFF);
    step_cycle(1'b0, 1'b1, 1'b0);
    check_eq("wrap_ts_next", 32'(evt_ts), 32'(2 + FLT));

    // reset mid-operation discards contents, counting restarts at 0
    pulse(1'b0);
    check_eq("pre_reset_level", 32'(level), 2);
    apply_reset();
    run_to(3 - FLT, 1'b0, 1'b0, 1'b0);
    step_cycle(1'b1, 1'b0, 1'b0);
    step_cycle(1'b1, 1'b0, 1'b0);
    step_cycle(1'b0, 1'b0, 1'b0);
    step_cycle(1'b0, 1'b0, 1'b0);
    check_eq("post_reset_level", 32'(level), 1);
    check_eq("post_reset_ts", 32'(evt_ts), 32'h3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
